// File: rtl/prbs_mon_pkg.sv
// prbs_mon_pkg
//   Shared types and helpers for the PRBS7 (x^7 + x^6 + 1) lane monitor.
//   - state_t      : monitor FSM encoding, also driven out on state_o
//   - PRBS_TAP_*   : polynomial taps, b[n] = b[n-6] ^ b[n-7]
//   - prbs7_next4  : predicts the next 4-bit word from a 7-bit history
//   - popcount4    : number of set bits in a 4-bit mismatch vector
package prbs_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_VERIFY = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int PRBS_TAP_A = 6;
  localparam int PRBS_TAP_B = 7;

  // History layout: hist[0] is the newest bit, hist[6] the oldest, so the
  // bit k+1 positions back in time lives at hist[k].
  typedef struct packed {
    logic [3:0] bits;  // predicted word, bit 3 earliest in time
    logic [6:0] hist;  // history after the 4 predicted bits are appended
  } prbs_pred_t;

  // Generates four bits serially; each predicted bit is fed back into the
  // history before the next one is produced, and the first bit ends up in
  // bit 3 after the four left shifts.
  function automatic prbs_pred_t prbs7_next4(input logic [6:0] hist);
    prbs_pred_t pred;
    logic [6:0] h;
    logic       b;
    h         = hist;
    pred.bits = '0;
    for (int i = 0; i < 4; i++) begin
      b         = h[PRBS_TAP_A-1] ^ h[PRBS_TAP_B-1];
      pred.bits = {pred.bits[2:0], b};
      h         = {h[5:0], b};
    end
    pred.hist = h;
    return pred;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/prbs_sat_counter.sv
// prbs_sat_counter
//   Saturating up-counter with synchronous clear. Clear wins over a
//   same-cycle increment; once all ones the count holds until cleared.
// Ports:
//   clk_i     in  1      clock
//   rst_i     in  1      asynchronous active-high reset
//   clear_i   in  1      synchronous clear to zero
//   inc_en_i  in  1      add inc_i this cycle
//   inc_i     in  INC_W  increment amount
//   count_o   out W      current count
module prbs_sat_counter #(
  parameter int W     = 32,
  parameter int INC_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             inc_en_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     count_o
);

  localparam int SUM_W = W + 1;

  // One extra bit catches the carry out that signals saturation.
  logic [W:0] sum;

  always_comb begin
    sum = {1'b0, count_o} + SUM_W'(inc_i);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (inc_en_i) begin
      count_o <= sum[W] ? '1 : sum[W-1:0];
    end
  end

endmodule

// File: rtl/prbs7_monitor_x2.sv
// prbs7_monitor_x2
//   Self-synchronising PRBS7 checker for the x2-geared RX lane (4 bits per
//   RX fabric clock, bit 3 earliest). Acquires the sequence from the line,
//   verifies it for LOCK_WORDS clean words, then free-runs its own predictor
//   while counting errored bits and words. Too many errored words inside one
//   WIN_WORDS window drop the monitor back to acquisition.
// Ports:
//   clk_i          in  1      RX fabric clock
//   rst_i          in  1      asynchronous active-high reset
//   prbs_en_i      in  1      enable; low forces IDLE
//   clear_i        in  1      zero the statistics counters and lock_lost_o
//   data_in_i      in  4      received word, bit 3 earliest
//   locked_o       out 1      high while LOCKED
//   err_o          out 1      one-cycle pulse per errored LOCKED word
//   lock_lost_o    out 1      sticky, set on LOCKED -> ACQ
//   bit_err_cnt_o  out CNT_W  saturating count of mismatched bits
//   word_cnt_o     out CNT_W  saturating count of LOCKED words
//   state_o        out 2      0 IDLE, 1 ACQ, 2 VERIFY, 3 LOCKED
module prbs7_monitor_x2
  import prbs_mon_pkg::*;
#(
  parameter int LOCK_WORDS  = 16,
  parameter int WIN_WORDS   = 64,
  parameter int LOSS_THRESH = 8,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             prbs_en_i,
  input  logic             clear_i,
  input  logic [3:0]       data_in_i,
  output logic             locked_o,
  output logic             err_o,
  output logic             lock_lost_o,
  output logic [CNT_W-1:0] bit_err_cnt_o,
  output logic [CNT_W-1:0] word_cnt_o,
  output logic [1:0]       state_o
);

  // Sized for the largest legal LOCK_WORDS (255) and WIN_WORDS (1023).
  localparam int CLEAN_CW = 8;
  localparam int WIN_CW   = 10;

  state_t              state_q, state_d;
  logic [6:0]          hist_q;
  logic                acq_phase_q;
  logic [CLEAN_CW-1:0] clean_cnt_q;
  logic [WIN_CW-1:0]   win_cnt_q;
  logic [WIN_CW-1:0]   errw_cnt_q;
  logic                err_q;
  logic                lock_lost_q;

  prbs_pred_t          pred;
  logic [2:0]          mism;
  logic                word_err;
  logic                verify_err;
  logic                in_locked;
  logic [WIN_CW-1:0]   errw_inc;
  logic                loss_event;
  logic                win_end;

  // ---------------------------------------------------------------------
  // Prediction and compare
  // ---------------------------------------------------------------------
  always_comb begin
    pred       = prbs7_next4(hist_q);
    mism       = popcount4(pred.bits ^ data_in_i);
    word_err   = (mism != 3'd0);
    // An all-zero history predicts all zeros forever; refuse to accept it.
    verify_err = word_err || (hist_q == 7'd0);
    in_locked  = (state_q == ST_LOCKED);
    errw_inc   = errw_cnt_q + 1'b1;
    loss_event = in_locked && word_err && (errw_inc == WIN_CW'(LOSS_THRESH));
    win_end    = (win_cnt_q == WIN_CW'(WIN_WORDS - 1));
  end

  // ---------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: state_d takes a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (!prbs_en_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_d = ST_ACQ;
        ST_ACQ:    if (acq_phase_q) state_d = ST_VERIFY;
        ST_VERIFY: begin
          if (verify_err) begin
            state_d = ST_ACQ;
          end else if (clean_cnt_q == CLEAN_CW'(LOCK_WORDS - 1)) begin
            state_d = ST_LOCKED;
          end
        end
        ST_LOCKED: if (loss_event) state_d = ST_ACQ;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    locked_o    = in_locked;
    state_o     = state_q;
    err_o       = err_q;
    lock_lost_o = lock_lost_q;
  end

  // ---------------------------------------------------------------------
  // History, acquisition, verify and window counters
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q      <= '0;
      acq_phase_q <= 1'b0;
      clean_cnt_q <= '0;
      win_cnt_q   <= '0;
      errw_cnt_q  <= '0;
      err_q       <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      err_q       <= in_locked && word_err;
      acq_phase_q <= 1'b0;

      // A loss event is a set; it overrides a same-cycle clear.
      if (loss_event && prbs_en_i) begin
        lock_lost_q <= 1'b1;
      end else if (clear_i) begin
        lock_lost_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          clean_cnt_q <= '0;
        end
        ST_ACQ: begin
          // Two words fill the 7-bit history (the oldest of 8 bits drops).
          hist_q      <= {hist_q[2:0], data_in_i};
          acq_phase_q <= ~acq_phase_q;
          clean_cnt_q <= '0;
        end
        ST_VERIFY: begin
          hist_q      <= {hist_q[2:0], data_in_i};
          clean_cnt_q <= verify_err ? '0 : clean_cnt_q + 1'b1;
          win_cnt_q   <= '0;
          errw_cnt_q  <= '0;
        end
        ST_LOCKED: begin
          // Free-run on the prediction so line errors cannot corrupt it.
          hist_q <= pred.hist;
          if (loss_event) begin
            win_cnt_q  <= '0;
            errw_cnt_q <= '0;
          end else if (win_end) begin
            win_cnt_q  <= '0;
            errw_cnt_q <= '0;
          end else begin
            win_cnt_q  <= win_cnt_q + 1'b1;
            errw_cnt_q <= word_err ? errw_inc : errw_cnt_q;
          end
        end
        default: begin
          clean_cnt_q <= '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Statistics
  // ---------------------------------------------------------------------
  prbs_sat_counter #(
    .W     (CNT_W),
    .INC_W (3)
  ) u_bit_err_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .inc_en_i (in_locked),
    .inc_i    (mism),
    .count_o  (bit_err_cnt_o)
  );

  prbs_sat_counter #(
    .W     (CNT_W),
    .INC_W (1)
  ) u_word_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (clear_i),
    .inc_en_i (in_locked),
    .inc_i    (1'b1),
    .count_o  (word_cnt_o)
  );

endmodule

// File: doc/prbs7_monitor_x2.md
Name: prbs7_monitor_x2

Overview:
- Self-synchronising PRBS7 (x^7+x^6+1) checker with lock tracking and error statistics.
- Consumes the bit-reversed 4-bit-per-cycle parallel word from the RX IOD lane (x2 gearing) on the RX fabric clock, downstream of the bit-reversal stage.
- Replaces the bare pass/fail checker with an acquisition/lock FSM, a loss-of-lock detector and saturating bit-error and word counters.
- Counters are readable by SmartDebug/fabric logic.

Parameters:
- LOCK_WORDS, 16: consecutive error-free words in VERIFY required to declare lock. Range 1..255.
- WIN_WORDS, 64: length in words of the loss-of-lock observation window in LOCKED. Range 2..1023.
- LOSS_THRESH, 8: errored words within one window that force resynchronisation. Range 1..WIN_WORDS.
- CNT_W, 32: width of the statistics counters. Range 16..48.

Ports:
- clk_i  in  1  RX fabric clock (RX_CLK_G domain)
- rst_i  in  1  reset, asynchronous assert, active-high
- prbs_en_i  in  1  enable; 0 forces IDLE
- clear_i  in  1  synchronous pulse: zero counters and sticky flags
- data_in_i  in  4  received word; bit 3 is the earliest bit in time
- locked_o  out  1  high in LOCKED state
- err_o  out  1  registered; high for one cycle per LOCKED word with ≥1 bit mismatch
- lock_lost_o  out  1  sticky; set on LOCKED->ACQ transition
- bit_err_cnt_o  out  CNT_W  saturating count of mismatched bits while LOCKED
- word_cnt_o  out  CNT_W  saturating count of words checked while LOCKED
- state_o  out  2  current FSM state: 0 IDLE, 1 ACQ, 2 VERIFY, 3 LOCKED

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, the history register is 0 and all counters are 0.
- Bit rule: b[n] = b[n-6] ^ b[n-7]. A 7-bit history H holds the last 7 bits. The 4 predicted bits are computed serially in one cycle: earliest bit first (maps to bit 3), with each predicted bit feeding the next.
- Mismatch: M = popcount(predicted ^ data_in_i), range 0..4, 3-bit result.

FSM:
- IDLE: counters hold. When prbs_en_i=1, go to ACQ next cycle.
- ACQ: shift the received words into H for 2 cycles (8 bits; H keeps the latest 7), then go to VERIFY.
- VERIFY: compare each word against prediction; H is loaded with the received bits.
  - M=0: increment the clean counter. When the count reaches LOCK_WORDS, go to LOCKED.
  - M≠0: go to ACQ and clear the clean counter.
  - An all-zero history (H=0) counts as an error, so the lock-up state cannot be accepted.
- LOCKED: H advances with the predicted bits (free-running, so bit errors do not propagate).
  - word_cnt_o increments by 1 and bit_err_cnt_o increments by M, both saturating at all ones.
  - err_o = (M≠0), registered, so it appears 1 cycle after the word.
  - Window counter counts words 0..WIN_WORDS-1; errored-word counter counts words with M≠0.
  - If the errored-word count reaches LOSS_THRESH within a window: go to ACQ and set lock_lost_o.
  - At window wrap, both window counters restart from 0. The word that completes the window is counted before the restart.
- prbs_en_i=0 in any state: go to IDLE next cycle; locked_o drops. Counters and sticky flag hold.
- clear_i: zeroes bit_err_cnt_o, word_cnt_o and lock_lost_o. FSM state is unaffected.
  - clear_i has priority over a same-cycle increment: the result is 0.
  - If clear_i coincides with a loss event, lock_lost_o ends set (the set wins).
- Latency: data word to err_o and counter update is 1 cycle. locked_o asserts 1 cycle after the LOCK_WORDS-th clean word.
- rst_i mid-operation: everything returns to reset values immediately (asynchronous).

Decomposition:
- Package prbs_mon_pkg contains:
  - state enum (IDLE/ACQ/VERIFY/LOCKED)
  - PRBS7 tap constants (6, 7)
  - function prbs7_next4(H) returning the 4 predicted bits and the next H
  - function popcount4
- Sub-module prbs_sat_counter (parameterised width, clear, increment amount), instantiated twice.

Test Plan:
- Clean PRBS7 stream, seed 7'h7F, prbs_en_i=1 → locked_o rises at cycle 2+16+1=19 after enable; err_o stays 0; word_cnt_o=100 after 100 locked words.
- Locked; flip bit 2 in one word and bits 0,3 in another (3 errored bits total) → err_o pulses twice; bit_err_cnt_o=3; locked_o stays 1.
- Locked; corrupt 8 words within one 64-word window → transition to ACQ; lock_lost_o=1; relock after 18 clean words; counters hold their values.
- Locked; 7 errored words per window over 3 windows → never loses lock; bit_err_cnt_o ≥ 21.
- All-zero input → never leaves ACQ/VERIFY; locked_o=0.
- CNT_W=16 with errors driving bit_err_cnt_o to 16'hFFFF → saturates. Then clear_i concurrent with an errored word → bit_err_cnt_o=0. rst_i mid-LOCKED → all outputs 0 asynchronously.
